// File: rtl/bsg_fifo_pkg.sv
// Shared FIFO types: occupancy encoding for
// small in-order buffers.
package bsg_fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } count_e;

endpackage

// File: rtl/bsg_dff_en_reset_n.sv
// Enabled register with asynchronous
// active-low clear to zero.
module bsg_dff_en_reset_n #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bsg_yumi_to_ready_sender.sv
// Valid/yumi source to valid/ready sink bridge
// through a 2-entry registered in-order buffer.
module bsg_yumi_to_ready_sender #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               yumi_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i
);

  import bsg_fifo_pkg::*;

  count_e count_q, count_d;
  logic   rd_ptr_q, rd_ptr_d;
  logic   wr_ptr_q, wr_ptr_d;
  logic   enq, deq;
  logic   [1:0] mem_en;
  logic   [width_p-1:0] mem0, mem1;

  // yumi_o looks only at occupancy, never at ready_i
  assign yumi_o = reset_n_i & v_i & (count_q != TWO);
  assign enq    = yumi_o;
  assign v_o    = (count_q != EMPTY);
  assign deq    = v_o & ready_i;
  assign data_o = rd_ptr_q ? mem1 : mem0;

  assign mem_en[0] = enq & ~wr_ptr_q;
  assign mem_en[1] = enq &  wr_ptr_q;

  bsg_dff_en_reset_n #(.width_p(width_p)) u_mem0 (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (mem_en[0]),
    .data_i    (data_i),
    .data_o    (mem0)
  );

  bsg_dff_en_reset_n #(.width_p(width_p)) u_mem1 (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (mem_en[1]),
    .data_i    (data_i),
    .data_o    (mem1)
  );

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q ^ deq;
    wr_ptr_d = wr_ptr_q ^ enq;
    unique case (count_q)
      EMPTY: begin
        if (enq) count_d = ONE;
      end
      ONE: begin
        if (enq & ~deq) count_d = TWO;
        else if (~enq & deq) count_d = EMPTY;
      end
      TWO: begin
        if (deq) count_d = ONE;
      end
      default: count_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q  <= EMPTY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

`ifndef SYNTHESIS
  logic               hold_q;
  logic [width_p-1:0] hold_data_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) hold_q <= 1'b0;
    else            hold_q <= v_o & ~ready_i;
  end

  always_ff @(posedge clk_i) begin
    hold_data_q <= data_o;
  end

  // a stalled word must stay put until taken
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (count_q != 2'd3);
      if (hold_q) begin
        assert (v_o);
        assert (data_o == hold_data_q);
      end
    end
  end
`endif

endmodule
